// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared types and helpers for the ADC channel scanner.
//   scan_state_t : scanner FSM states
//   ADC_DATA_W   : width of one conversion result
//   ADC_CH_W     : width of an ADC channel number
//   ch_of()      : pick one slot's channel out of a packed channel map
package adc_scan_pkg;
  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 5;
  localparam int MAX_CH     = 8;

  typedef enum logic [2:0] {IDLE, CMD, WAIT, ACC, UPD} scan_state_t;

  // map is the channel list widened to the maximum slot count
  function automatic logic [ADC_CH_W-1:0] ch_of(input logic [MAX_CH*ADC_CH_W-1:0] map,
                                                input logic [2:0] idx);
    return map[int'(idx)*ADC_CH_W +: ADC_CH_W];
  endfunction
endpackage

// File: rtl/adc_avg_accum.sv
// adc_avg_accum: sample accumulator and sample counter for one scan slot.
//   clk, rst : clock, async active-high reset
//   clear    : drop the accumulated sum and the sample count
//   add      : add data to the sum and count one more sample
//   data     : sample to add
//   done     : the sample being added now completes the 2^AVG_LOG2 set
//   avg      : average including the sample on data, truncated toward zero
module adc_avg_accum import adc_scan_pkg::*; #(
  parameter int AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  add,
  input  logic [ADC_DATA_W-1:0] data,
  output logic                  done,
  output logic [ADC_DATA_W-1:0] avg
);
  localparam int AW = ADC_DATA_W + AVG_LOG2;

  logic [AW-1:0]     acc, sum;
  logic [AVG_LOG2:0] cnt;

  // avg looks at the sum including the current sample so the result can be
  // registered on the same edge that absorbs the last sample
  assign sum  = acc + AW'(data);
  assign avg  = sum[AW-1:AVG_LOG2];
  assign done = (cnt == (AVG_LOG2+1)'((1 << AVG_LOG2) - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/adc_channel_scanner.sv
// adc_channel_scanner: round-robin scanner for the modular ADC command/response
// stream. Issues one command at a time, averages 2^AVG_LOG2 samples per slot,
// keeps one result per slot and flags wrong-channel responses and timeouts.
//   MAX10_CLK1_50, reset : clock, async active-high reset
//   enable               : run the scan
//   command_*            : command stream to the ADC
//   response_*           : response stream from the ADC
//   result_flat          : averaged result per slot, slot i at [12i+11:12i]
//   result_valid/idx     : one-cycle pulse and slot of a result update
//   err_mismatch/timeout : sticky error flags, cleared by err_clear
module adc_channel_scanner import adc_scan_pkg::*; #(
  parameter int                          NUM_CH   = 2,
  parameter logic [NUM_CH*ADC_CH_W-1:0] CH_MAP   = {5'd2, 5'd1},
  parameter int                          AVG_LOG2 = 2,
  parameter int                          TIMEOUT  = 1023
) (
  input  logic                         MAX10_CLK1_50,
  input  logic                         reset,
  input  logic                         enable,
  output logic                         command_valid,
  output logic [ADC_CH_W-1:0]          command_channel,
  output logic                         command_startofpacket,
  output logic                         command_endofpacket,
  input  logic                         command_ready,
  input  logic                         response_valid,
  input  logic [ADC_CH_W-1:0]          response_channel,
  input  logic [ADC_DATA_W-1:0]        response_data,
  output logic [NUM_CH*ADC_DATA_W-1:0] result_flat,
  output logic                         result_valid,
  output logic [2:0]                   result_idx,
  output logic                         err_mismatch,
  output logic                         err_timeout,
  input  logic                         err_clear
);
  localparam logic [MAX_CH*ADC_CH_W-1:0] MAP = (MAX_CH*ADC_CH_W)'(CH_MAP);

  scan_state_t                         state, nxt;
  logic [2:0]                          slot;
  logic [15:0]                         tcnt;
  logic [ADC_DATA_W-1:0]               rdata, avg;
  logic [NUM_CH-1:0][ADC_DATA_W-1:0]   res;
  logic                                hit, tmo, done, set_mm, set_to;

  assign command_channel       = ch_of(MAP, slot);
  assign command_startofpacket = 1'b1;
  assign command_endofpacket   = 1'b1;
  assign result_flat           = res;

  assign hit    = (state == WAIT) && response_valid && (response_channel == command_channel);
  assign tmo    = (state == WAIT) && (tcnt == 16'(TIMEOUT - 1));
  // anything other than the expected response counts as a mismatch
  assign set_mm = response_valid && !hit;
  // a response on the last allowed cycle still wins over the timeout
  assign set_to = tmo && !hit;

  adc_avg_accum #(.AVG_LOG2(AVG_LOG2)) u_acc (
    .clk   (MAX10_CLK1_50),
    .rst   (reset),
    .clear (state == UPD),
    .add   (state == ACC),
    .data  (rdata),
    .done  (done),
    .avg   (avg)
  );

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt           = state;
    command_valid = 1'b0;
    case (state)
      IDLE: if (enable) nxt = CMD;
      CMD: begin
        // valid is gated by enable so a stop never leaves a pending handshake
        command_valid = enable;
        if (!enable)            nxt = IDLE;
        else if (command_ready) nxt = WAIT;
      end
      WAIT: begin
        if (hit)      nxt = ACC;
        else if (tmo) nxt = CMD;
      end
      ACC:     nxt = done ? UPD : (enable ? CMD : IDLE);
      UPD:     nxt = enable ? CMD : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      slot         <= '0;
      tcnt         <= '0;
      rdata        <= '0;
      res          <= '0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      err_mismatch <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (state == CMD)       tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + 16'd1;
      if (hit) rdata <= response_data;

      result_valid <= (state == ACC) && done;
      if ((state == ACC) && done) begin
        result_idx <= slot;
        for (int i = 0; i < NUM_CH; i++)
          if (slot == 3'(i)) res[i] <= avg;
      end
      if (state == UPD) slot <= (slot == 3'(NUM_CH - 1)) ? 3'd0 : slot + 3'd1;

      if (set_mm)         err_mismatch <= 1'b1;
      else if (err_clear) err_mismatch <= 1'b0;
      if (set_to)         err_timeout  <= 1'b1;
      else if (err_clear) err_timeout  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_adc_channel_scanner.sv
// tb_adc_channel_scanner: randomized bench for the channel scanner with a
// sample-list reference model; a second instance covers single-sample mode.
module tb_adc_channel_scanner;
  logic        clk = 1'b0;
  logic        reset, enable, command_ready, response_valid, err_clear;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        command_valid, command_startofpacket, command_endofpacket;
  logic [4:0]  command_channel;
  logic [23:0] result_flat;
  logic        result_valid, err_mismatch, err_timeout;
  logic [2:0]  result_idx;

  logic        b_enable, b_ready, b_rv, b_cv, b_sop, b_eop, b_res_valid, b_mm, b_to;
  logic [4:0]  b_rch, b_ch;
  logic [11:0] b_rd, b_flat;
  logic [2:0]  b_idx;

  int total = 0;
  int bad   = 0;

  // reference model: slot pointer, samples taken so far, their sum, results
  int          mslot, mcnt, msum;
  logic [11:0] mres [2];

  always #5 clk = ~clk;

  adc_channel_scanner #(.NUM_CH(2), .CH_MAP({5'd2, 5'd1}), .AVG_LOG2(2), .TIMEOUT(16)) dut (
    .MAX10_CLK1_50(clk), .reset(reset), .enable(enable),
    .command_valid(command_valid), .command_channel(command_channel),
    .command_startofpacket(command_startofpacket), .command_endofpacket(command_endofpacket),
    .command_ready(command_ready), .response_valid(response_valid),
    .response_channel(response_channel), .response_data(response_data),
    .result_flat(result_flat), .result_valid(result_valid), .result_idx(result_idx),
    .err_mismatch(err_mismatch), .err_timeout(err_timeout), .err_clear(err_clear));

  adc_channel_scanner #(.NUM_CH(1), .CH_MAP(5'd3), .AVG_LOG2(0), .TIMEOUT(1023)) dut_b (
    .MAX10_CLK1_50(clk), .reset(reset), .enable(b_enable),
    .command_valid(b_cv), .command_channel(b_ch),
    .command_startofpacket(b_sop), .command_endofpacket(b_eop),
    .command_ready(b_ready), .response_valid(b_rv),
    .response_channel(b_rch), .response_data(b_rd),
    .result_flat(b_flat), .result_valid(b_res_valid), .result_idx(b_idx),
    .err_mismatch(b_mm), .err_timeout(b_to), .err_clear(1'b0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] mchan(input int s);
    return (s == 0) ? 5'd1 : 5'd2;
  endfunction

  function automatic logic [31:0] mflat();
    return {8'h0, mres[1], mres[0]};
  endfunction

  task automatic wait_cmd();
    int n;
    n = 0;
    while (!command_valid && n < 40) begin tick(); n++; end
    chk("cmd_valid", 32'(command_valid), 32'd1);
    chk("cmd_ch", 32'(command_channel), 32'(mchan(mslot)));
  endtask

  // one full sample: command, optional ready stall, optional stray response,
  // optional enable drop during WAIT, then the real response and its effects
  task automatic txn(input logic [11:0] d, input int rdly, input int rlat,
                     input bit stray, input bit drop);
    wait_cmd();
    for (int i = 0; i < rlat; i++) begin
      tick();
      chk("hold_valid", 32'(command_valid), 32'd1);
      chk("hold_ch", 32'(command_channel), 32'(mchan(mslot)));
    end
    command_ready = 1'b1; tick(); command_ready = 1'b0;
    chk("wait_novalid", 32'(command_valid), 32'd0);
    if (drop) enable = 1'b0;
    if (stray) begin
      response_valid = 1'b1; response_channel = 5'd7; response_data = 12'hABC;
      tick(); response_valid = 1'b0;
      chk("mm_set", 32'(err_mismatch), 32'd1);
      chk("mm_stay", 32'(command_valid), 32'd0);
      err_clear = 1'b1; tick(); err_clear = 1'b0;
      chk("mm_clr", 32'(err_mismatch), 32'd0);
    end
    repeat (rdly) tick();
    response_valid = 1'b1; response_channel = mchan(mslot); response_data = d;
    tick(); response_valid = 1'b0;
    msum += int'(d); mcnt++;
    tick();
    if (mcnt == 4) begin
      mres[mslot] = 12'(msum / 4);
      chk("res_valid", 32'(result_valid), 32'd1);
      chk("res_idx", 32'(result_idx), 32'(mslot));
      chk("res_flat", 32'(result_flat), mflat());
      mslot = (mslot + 1) % 2; mcnt = 0; msum = 0;
      tick();
      chk("res_pulse", 32'(result_valid), 32'd0);
    end else begin
      chk("no_res", 32'(result_valid), 32'd0);
      chk("flat_hold", 32'(result_flat), mflat());
    end
    if (drop) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("stopped", 32'(command_valid), 32'd0);
      end
      enable = 1'b1; tick();
    end
    chk("reissue", 32'(command_valid), 32'd1);
  endtask

  task automatic rnd_txn(input bit allow_flags);
    txn(12'($urandom_range(0, 4095)), $urandom_range(0, 5), $urandom_range(0, 3),
        allow_flags && ($urandom_range(0, 5) == 0), allow_flags && ($urandom_range(0, 5) == 0));
  endtask

  task automatic tmo_test();
    wait_cmd();
    command_ready = 1'b1; tick(); command_ready = 1'b0;
    repeat (15) tick();
    chk("to_early", 32'(err_timeout), 32'd0);
    chk("to_still_wait", 32'(command_valid), 32'd0);
    tick();
    chk("to_set", 32'(err_timeout), 32'd1);
    chk("to_reissue", 32'(command_valid), 32'd1);
    chk("to_same_ch", 32'(command_channel), 32'(mchan(mslot)));
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("to_clr", 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] bd;
    reset = 1'b1; enable = 1'b0; command_ready = 1'b0; response_valid = 1'b0;
    err_clear = 1'b0; response_channel = '0; response_data = '0;
    b_enable = 1'b0; b_ready = 1'b0; b_rv = 1'b0; b_rch = '0; b_rd = '0;
    mslot = 0; mcnt = 0; msum = 0; mres[0] = '0; mres[1] = '0;
    repeat (2) tick();
    reset = 1'b0; tick();
    chk("rst_cv", 32'(command_valid), 32'd0);
    chk("rst_ch", 32'(command_channel), 32'd1);
    chk("rst_flat", 32'(result_flat), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_idx", 32'(result_idx), 32'd0);
    chk("rst_mm", 32'(err_mismatch), 32'd0);
    chk("rst_to", 32'(err_timeout), 32'd0);
    chk("sop_eop", 32'({command_startofpacket, command_endofpacket}), 32'd3);

    // unsolicited response while idle, then set-vs-clear priority
    response_valid = 1'b1; response_channel = 5'd1; tick(); response_valid = 1'b0;
    chk("mm_idle", 32'(err_mismatch), 32'd1);
    err_clear = 1'b1; response_valid = 1'b1; tick(); response_valid = 1'b0;
    chk("mm_set_wins", 32'(err_mismatch), 32'd1);
    tick(); err_clear = 1'b0;
    chk("mm_cleared", 32'(err_mismatch), 32'd0);

    enable = 1'b1;
    chk("pre_cmd", 32'(command_valid), 32'd0);
    tick();
    chk("first_cmd", 32'(command_valid), 32'd1);

    txn(12'd100, 2, 0, 0, 0); txn(12'd101, 2, 0, 0, 0);
    txn(12'd102, 2, 0, 0, 0); txn(12'd105, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) txn(12'd4000, 2, 0, 0, 0);
    chk("dir_res0", 32'(result_flat[11:0]), 32'd102);
    chk("dir_res1", 32'(result_flat[23:12]), 32'd4000);

    txn(12'($urandom_range(0, 4095)), 2, 0, 1, 0);
    txn(12'($urandom_range(0, 4095)), 1, 10, 0, 0);
    tmo_test();
    txn(12'($urandom_range(0, 4095)), 3, 0, 0, 1);
    txn(12'($urandom_range(0, 4095)), 3, 0, 0, 0);
    tmo_test();
    for (int i = 0; i < 24; i++) rnd_txn(1'b1);

    // reset in the middle of a WAIT, with the response still arriving
    wait_cmd();
    command_ready = 1'b1; tick(); command_ready = 1'b0;
    tick();
    enable = 1'b0; reset = 1'b1; #1;
    chk("mid_rst_cv", 32'(command_valid), 32'd0);
    chk("mid_rst_ch", 32'(command_channel), 32'd1);
    chk("mid_rst_flat", 32'(result_flat), 32'd0);
    chk("mid_rst_rv", 32'(result_valid), 32'd0);
    chk("mid_rst_idx", 32'(result_idx), 32'd0);
    chk("mid_rst_err", 32'({err_mismatch, err_timeout}), 32'd0);
    tick(); reset = 1'b0;
    response_valid = 1'b1; response_channel = mchan(mslot); response_data = 12'h123;
    tick(); response_valid = 1'b0;
    chk("mm_late", 32'(err_mismatch), 32'd1);
    mslot = 0; mcnt = 0; msum = 0; mres[0] = '0; mres[1] = '0;
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    enable = 1'b1; tick();
    for (int i = 0; i < 12; i++) rnd_txn(1'b0);

    // single-sample instance: result is the raw sample
    b_enable = 1'b1; tick();
    chk("b_cv", 32'(b_cv), 32'd1);
    chk("b_ch", 32'(b_ch), 32'd3);
    for (int k = 0; k < 3; k++) begin
      bd = (k == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
      b_ready = 1'b1; tick(); b_ready = 1'b0;
      tick();
      b_rv = 1'b1; b_rch = 5'd3; b_rd = bd; tick(); b_rv = 1'b0;
      tick();
      chk("b_res_valid", 32'(b_res_valid), 32'd1);
      chk("b_res", 32'(b_flat), 32'(bd));
      chk("b_idx", 32'(b_idx), 32'd0);
      tick();
      chk("b_reissue", 32'(b_cv), 32'd1);
    end
    chk("b_err", 32'({b_mm, b_to}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
